// File: rtl/apb_req_arbiter.sv
// Two-port round-robin front end for the APB master's processor-side interface.
// One transfer is outstanding at a time, and a watchdog aborts any transfer whose done never arrives.
module apb_req_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        r0_req,
   input  logic        r0_write,
   input  logic [8:0]  r0_addr,
   input  logic [15:0] r0_wdata,
   output logic        r0_ack,
   output logic [15:0] r0_rdata,
   output logic        r0_err,
   input  logic        r1_req,
   input  logic        r1_write,
   input  logic [8:0]  r1_addr,
   input  logic [15:0] r1_wdata,
   output logic        r1_ack,
   output logic [15:0] r1_rdata,
   output logic        r1_err,
   output logic        m_wr_en,
   output logic        m_rd_en,
   output logic [8:0]  m_wr_addr,
   output logic [8:0]  m_rd_addr,
   output logic [15:0] m_wr_data,
   input  logic        m_wr_done,
   input  logic        m_rd_done,
   input  logic [15:0] m_rd_data
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state;
   logic          last_grant;
   logic          gnt;
   logic          cur_write;
   logic [CW-1:0] cnt;

   logic          sel1;
   logic          g_write;
   logic [8:0]    g_addr;
   logic [15:0]   g_wdata;
   logic          done;
   logic          timeout;
   logic [15:0]   resp_rdata;

   always_comb begin
      sel1 = r1_req;
      if (r0_req && r1_req)
         sel1 = ~last_grant;
      g_write    = sel1 ? r1_write : r0_write;
      g_addr     = sel1 ? r1_addr  : r0_addr;
      g_wdata    = sel1 ? r1_wdata : r0_wdata;
      done       = cur_write ? m_wr_done : m_rd_done;
      // a done in the final count cycle beats the timeout
      timeout    = (cnt == CNT_LAST) && !done;
      resp_rdata = done ? m_rd_data : '0;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         cur_write  <= 1'b0;
         cnt        <= '0;
         m_wr_en    <= 1'b0;
         m_rd_en    <= 1'b0;
         m_wr_addr  <= '0;
         m_rd_addr  <= '0;
         m_wr_data  <= '0;
         r0_ack     <= 1'b0;
         r0_err     <= 1'b0;
         r0_rdata   <= '0;
         r1_ack     <= 1'b0;
         r1_err     <= 1'b0;
         r1_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (r0_req || r1_req) begin
                  gnt       <= sel1;
                  cur_write <= g_write;
                  cnt       <= '0;
                  if (g_write) begin
                     m_wr_en   <= 1'b1;
                     m_wr_addr <= g_addr;
                     m_wr_data <= g_wdata;
                  end else begin
                     m_rd_en   <= 1'b1;
                     m_rd_addr <= g_addr;
                  end
                  state <= S_ISSUE;
               end
            end
            // done may still be high from the previous transfer, so it is not looked at here
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (done || timeout) begin
                  m_wr_en <= 1'b0;
                  m_rd_en <= 1'b0;
                  state   <= S_RESP;
                  if (gnt) begin
                     r1_ack <= 1'b1;
                     r1_err <= timeout;
                     if (!cur_write)
                        r1_rdata <= resp_rdata;
                  end else begin
                     r0_ack <= 1'b1;
                     r0_err <= timeout;
                     if (!cur_write)
                        r0_rdata <= resp_rdata;
                  end
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESP: begin
               r0_ack     <= 1'b0;
               r1_ack     <= 1'b0;
               last_grant <= gnt;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
